step_counter: RTL

//   Parametrised arithmetic-step counter: the successor to the fixed +2 odd counter.

---
 rtl/step_counter_pkg.sv | 14 +
 rtl/step_counter_next.sv | 69 ++++++
 rtl/step_counter.sv | 52 +++++
 3 files changed

// File: rtl/step_counter_pkg.sv
// Shared types and default parameters for the step counter family.
// The saturating build is selected with STEP_COUNTER_SAT_EN; both builds share this package.
package step_counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_INIT  = 1;
    localparam int unsigned DEF_STEP  = 2;

endpackage

// File: rtl/step_counter_next.sv
// Combinational successor of the step counter: next value and window-crossing flag.
// Define STEP_COUNTER_SAT_EN to clamp at the window bounds instead of wrapping.
module step_counter_next
    import step_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned INIT  = DEF_INIT,
    parameter int unsigned STEP  = DEF_STEP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] next_val,
    output logic             crossed
);

    // One extra bit so count + STEP and INIT + STEP never overflow.
    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0] INIT_X = XW'(INIT);
    localparam logic [XW-1:0] STEP_X = XW'(STEP);
    localparam logic [XW-1:0] LOW_X  = INIT_X + STEP_X;
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

`ifdef STEP_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [XW-1:0] count_x;
    logic [XW-1:0] limit_x;
    logic [XW-1:0] sum_x;
    logic [XW-1:0] diff_x;
    dir_e          dir_s;

    assign count_x = {1'b0, count};
    assign limit_x = {1'b0, limit};
    assign sum_x   = count_x + STEP_X;
    assign diff_x  = count_x - STEP_X;
    assign dir_s   = dir_e'(dir);

    always_comb begin
        next_val = count;
        crossed  = 1'b0;
        case (dir_s)
            DIR_UP: begin
                if (sum_x > limit_x) begin
                    crossed  = 1'b1;
                    next_val = SAT ? limit : INIT_W;
                end else begin
                    next_val = WIDTH'(sum_x);
                end
            end
            DIR_DOWN: begin
                if (count_x < LOW_X) begin
                    crossed  = 1'b1;
                    next_val = SAT ? INIT_W : limit;
                end else begin
                    next_val = WIDTH'(diff_x);
                end
            end
            default: begin
                next_val = count;
                crossed  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/step_counter.sv
// Arithmetic-step counter over the window [INIT .. limit] with load and wrap pulse.
// Define STEP_COUNTER_SAT_EN for the saturating variant; ports are identical in both builds.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned INIT  = DEF_INIT,
    parameter int unsigned STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    logic [WIDTH-1:0] next_val;
    logic             crossed;

    step_counter_next #(
        .WIDTH (WIDTH),
        .INIT  (INIT),
        .STEP  (STEP)
    ) u_next (
        .count    (out),
        .dir      (dir),
        .limit    (limit),
        .next_val (next_val),
        .crossed  (crossed)
    );

    // rstn is active-high here: 1 forces the window start.
    always_ff @(posedge clk) begin
        if (rstn) begin
            out  <= WIDTH'(INIT);
            wrap <= 1'b0;
        end else if (load) begin
            out  <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
            out  <= next_val;
            wrap <= crossed;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
